// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory.
// Loads: byte/half/word lane extraction with sign or zero extension.
// Sub-word stores: read-modify-write, since the memory only writes full words.
// Misaligned or illegal requests are answered with an error and never reach memory.
module load_store_unit #(
  parameter int W = 32,
  parameter int D = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_req_store,
  input  logic [2:0]   i_req_funct3,
  input  logic [D-1:0] i_req_addr,
  input  logic [W-1:0] i_req_wdata,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [W-1:0] o_rsp_data,
  output logic         o_rsp_error,
  output logic [D-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_data,
  output logic         o_mem_read,
  output logic         o_mem_write,
  input  logic [W-1:0] i_mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    LOAD_WAIT,
    MERGE,
    RESP
  } state_t;

  state_t state, state_nxt;

  // Request fields captured at acceptance; everything downstream uses these.
  logic         store_p0;
  logic [2:0]   funct3_p0;
  logic [D-1:0] addr_p0;
  logic [W-1:0] wdata_p0;

  logic accept;
  logic word_store;

  // Illegal encodings, stores of unsigned widths, and misaligned H/W accesses.
  function automatic logic is_error(input logic store, input logic [2:0] f3,
                                    input logic [1:0] lo);
    logic err;
    err = 1'b0;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = lo[0];
      3'b010:  err = (lo != 2'b00);
      3'b100:  err = store;
      3'b101:  err = store | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Select the addressed little-endian lane and extend it to a full word.
  function automatic logic [W-1:0] load_format(input logic [W-1:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] lo);
    logic        [7:0]   b_u;
    logic        [15:0]  h_u;
    logic signed [7:0]   b_s;
    logic signed [15:0]  h_s;
    logic signed [W-1:0] ext_s;
    logic        [W-1:0] res;
    b_u   = word[8*lo +: 8];
    h_u   = word[16*lo[1] +: 16];
    b_s   = b_u;
    h_s   = h_u;
    ext_s = '0;
    res   = word;
    case (f3)
      3'b000: begin
        ext_s = b_s;
        res   = ext_s;
      end
      3'b001: begin
        ext_s = h_s;
        res   = ext_s;
      end
      3'b100:  res = {{(W-8){1'b0}}, b_u};
      3'b101:  res = {{(W-16){1'b0}}, h_u};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte or half-word of the old memory word.
  function automatic logic [W-1:0] store_merge(input logic [W-1:0] word,
                                               input logic [W-1:0] wdata,
                                               input logic [2:0] f3,
                                               input logic [1:0] lo);
    logic [W-1:0] res;
    res = word;
    if (f3[1:0] == 2'b00)
      res[8*lo +: 8] = wdata[7:0];
    else if (f3[1:0] == 2'b01)
      res[16*lo[1] +: 16] = wdata[15:0];
    else
      res = wdata;
    return res;
  endfunction

  assign o_req_ready = (state == IDLE);
  assign accept      = i_req_valid & o_req_ready;
  assign o_rsp_valid = (state == RESP);
  assign o_mem_addr  = {addr_p0[D-1:2], 2'b00};
  assign word_store  = store_p0 & (funct3_p0 == 3'b010);

  // State register; reset always lands in IDLE, abandoning any operation.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_error(i_req_store, i_req_funct3, i_req_addr[1:0]))
            state_nxt = RESP;
          else
            state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (word_store)
          state_nxt = RESP;
        else if (store_p0)
          state_nxt = MERGE;
        else
          state_nxt = LOAD_WAIT;
      end
      LOAD_WAIT: state_nxt = RESP;
      MERGE:     state_nxt = RESP;
      RESP: begin
        if (i_rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on acceptance; cleared by reset so the memory address starts at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      store_p0  <= 1'b0;
      funct3_p0 <= 3'b000;
      addr_p0   <= '0;
      wdata_p0  <= '0;
    end else if (accept) begin
      store_p0  <= i_req_store;
      funct3_p0 <= i_req_funct3;
      addr_p0   <= i_req_addr;
      wdata_p0  <= i_req_wdata;
    end
  end

  // Response payload: cleared on acceptance, filled with load data in LOAD_WAIT, held through RESP.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rsp_data  <= '0;
      o_rsp_error <= 1'b0;
    end else if (accept) begin
      o_rsp_data  <= '0;
      o_rsp_error <= is_error(i_req_store, i_req_funct3, i_req_addr[1:0]);
    end else if (state == LOAD_WAIT) begin
      o_rsp_data  <= load_format(i_mem_data, funct3_p0, addr_p0[1:0]);
    end
  end

  // Memory strobes and write data from state and latched fields; strobes are suppressed during reset.
  always_comb begin
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_data  = '0;
    case (state)
      ACCESS: begin
        if (word_store) begin
          o_mem_write = 1'b1;
          o_mem_data  = wdata_p0;
        end else begin
          o_mem_read  = 1'b1;
        end
      end
      MERGE: begin
        o_mem_write = 1'b1;
        o_mem_data  = store_merge(i_mem_data, wdata_p0, funct3_p0, addr_p0[1:0]);
      end
      default: ;
    endcase
    if (i_reset) begin
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of requests with expected
// response, latency and strobe counts, plus backpressure and mid-operation reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [64] = '{default: 32'h0};

  int n_vec = 0;
  int n_bad = 0;

  // Strobe counters, written only by the memory model.
  int rd_total = 0;
  int wr_total = 0;
  int addr_bad_total = 0;
  logic [7:0] exp_mem_addr = '0;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];

  load_store_unit #(.W(32), .D(8)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_store (req_store),
    .i_req_funct3(req_funct3),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_error (rsp_error),
    .o_mem_addr  (mem_addr),
    .o_mem_data  (mem_wdata),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .i_mem_data  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with registered read data.
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= mem[mem_addr[7:2]];
      rd_total  <= rd_total + 1;
    end
    if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_total <= wr_total + 1;
    end
    if ((mem_read || mem_write) && mem_addr != exp_mem_addr)
      addr_bad_total <= addr_bad_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Issue one request and check its response, latency and memory traffic.
  task automatic do_req(input vec_t v, input string name);
    int   lat;
    int   rd0, wr0, ab0;
    rsp_t e;
    rsp_t got;
    wait_ready();
    rd0 = rd_total; wr0 = wr_total; ab0 = addr_bad_total;
    exp_mem_addr = {v.addr[7:2], 2'b00};
    req_valid  = 1'b1;
    req_store  = v.store;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    e.data = v.exp_data;
    e.err  = v.exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 8'hFF;
    req_wdata = 32'hDEADBEEF;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(v.exp_lat));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      got.data = rsp_data;
      got.err  = rsp_error;
      check({name, "_data"}, got.data, e.data);
      check({name, "_err"}, 32'(got.err), 32'(e.err));
    end
    check({name, "_rd"}, 32'(rd_total - rd0), 32'(v.exp_rd));
    check({name, "_wr"}, 32'(wr_total - wr0), 32'(v.exp_wr));
    check({name, "_maddr"}, 32'(addr_bad_total - ab0), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[16];

  initial begin
    int wr0;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    //            store f3     addr   wdata         exp_data      err  lat rd wr
    tbl[0]  = '{1'b1, 3'b010, 8'h10, 32'h876543A1, 32'h00000000, 1'b0, 2, 0, 1};
    tbl[1]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'h876543A1, 1'b0, 3, 1, 0};
    tbl[2]  = '{1'b0, 3'b000, 8'h10, 32'h0,        32'hFFFFFFA1, 1'b0, 3, 1, 0};
    tbl[3]  = '{1'b0, 3'b100, 8'h13, 32'h0,        32'h00000087, 1'b0, 3, 1, 0};
    tbl[4]  = '{1'b0, 3'b001, 8'h12, 32'h0,        32'hFFFF8765, 1'b0, 3, 1, 0};
    tbl[5]  = '{1'b0, 3'b101, 8'h10, 32'h0,        32'h000043A1, 1'b0, 3, 1, 0};
    tbl[6]  = '{1'b1, 3'b000, 8'h11, 32'h000000CC, 32'h00000000, 1'b0, 3, 1, 1};
    tbl[7]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'h8765CCA1, 1'b0, 3, 1, 0};
    tbl[8]  = '{1'b1, 3'b001, 8'h12, 32'h00001234, 32'h00000000, 1'b0, 3, 1, 1};
    tbl[9]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'h1234CCA1, 1'b0, 3, 1, 0};
    tbl[10] = '{1'b0, 3'b010, 8'h12, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};
    tbl[11] = '{1'b1, 3'b001, 8'h13, 32'h0000FFFF, 32'h00000000, 1'b1, 1, 0, 0};
    tbl[12] = '{1'b1, 3'b100, 8'h10, 32'h000000EE, 32'h00000000, 1'b1, 1, 0, 0};
    tbl[13] = '{1'b0, 3'b011, 8'h10, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};
    tbl[14] = '{1'b0, 3'b000, 8'h11, 32'h0,        32'hFFFFFFCC, 1'b0, 3, 1, 0};
    tbl[15] = '{1'b0, 3'b101, 8'h12, 32'h0,        32'h00001234, 1'b0, 3, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", mem_wdata, 32'd0);

    for (int i = 0; i < 16; i++)
      do_req(tbl[i], $sformatf("vec%0d", i));

    // Backpressure on an LB response, with a stray request that must be ignored.
    wait_ready();
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 8'h10;
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'b010; req_addr = 8'h20; req_wdata = 32'h11111111;
    repeat (2) @(negedge clk);
    check("bp_first_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", c), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_hold%0d_data", c), rsp_data, 32'hFFFFFFA1);
      check($sformatf("bp_hold%0d_rdy", c), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("bp_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("bp_stray_ignored", 32'(rsp_valid), 32'd0);
    check("bp_stray_no_write", mem[8], 32'h0);

    // Reset while an SB sits in MERGE: the write must be dropped.
    wr0 = wr_total;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 8'h10;
    req_wdata = 32'h00000055;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_no_write", 32'(wr_total - wr0), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd1);
    check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    do_req('{1'b0, 3'b010, 8'h10, 32'h0, 32'h1234CCA1, 1'b0, 3, 1, 0}, "mrst_reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the word-addressed data memory of the RISC-V core, upstream of the memory. Accepts one RV32 load/store request at a time from execute. For loads it does byte-lane extraction with sign or zero extension. For sub-word stores it performs a read-modify-write, because the memory only writes full words. Misaligned or illegal accesses are reported as errors and never touch memory.

## Interface
- W, 32: data width; only 32 is supported.
- D, 8: byte-address width; matches the memory address width.

- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  unit can accept a request; equals (state==IDLE)
- i_req_store  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_req_addr  in  D  byte address
- i_req_wdata  in  W  store data; low bits are used for B/H
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer accepts the response
- o_rsp_data  out  W  formatted load data; 0 for stores and errors
- o_rsp_error  out  1  misaligned or illegal access
- o_mem_addr  out  D  {addr[D-1:2], 2'b00}
- o_mem_data  out  W  write data to memory
- o_mem_read  out  1  memory read strobe; data appears on i_mem_data the next cycle
- o_mem_write  out  1  memory write strobe
- i_mem_data  in  W  memory read data, registered inside the memory

## Operation
- Request is accepted on the i_req_valid & o_req_ready edge. On acceptance, latch store, funct3, addr and wdata.
- Error conditions:
  - funct3 ∈ {011,110,111}
  - store with funct3 100 or 101
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k = addr[1:0]. The half-word sits at bits [16·addr[1]+15 : 16·addr[1]].
- FSM:
  - IDLE: ready=1. On accept: error → RESP with error=1; otherwise → ACCESS.
  - ACCESS: a load or sub-word store asserts o_mem_read, then goes to LOAD_WAIT (load) or MERGE (store). A word store asserts o_mem_write with o_mem_data=wdata, then goes to RESP.
  - LOAD_WAIT: capture the selected lane of i_mem_data into o_rsp_data. B/H are sign-extended; BU/HU are zero-extended. → RESP.
  - MERGE: assert o_mem_write. o_mem_data = i_mem_data with the addressed lane replaced by wdata[7:0] or wdata[15:0]. → RESP.
  - RESP: o_rsp_valid=1. o_rsp_data and o_rsp_error stay stable until i_rsp_ready, then → IDLE.
- The memory strobes are decoded from state and latched fields only, never from the request inputs. Each strobe is asserted for exactly one cycle per operation.

## Timing
- Reset values:
  - state=IDLE
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_error=0
  - o_mem_read=0, o_mem_write=0, o_mem_addr=0, o_mem_data=0
  - o_req_ready=1 from the first cycle after reset deasserts
- Latency from accept edge N to the first cycle with o_rsp_valid high:
  - load: N+3
  - word store: N+2
  - sub-word store: N+3
  - error: N+1
- Throughput: one request in flight. A new request can be accepted at the earliest in the cycle after the response handshake.
- Response backpressure: RESP holds indefinitely with all outputs stable. o_req_ready stays 0.
- Reset mid-operation returns the FSM to IDLE on that edge. The o_mem_read and o_mem_write strobes are gated low while i_reset=1, so a pending MERGE write is dropped. Memory contents are not cleared.
- i_req_valid during non-IDLE states is ignored. The request is not captured.

## Test plan
- Word store 0x8765_43A1 to 0x10, then LW 0x10 → mem write at ACCESS, o_rsp_data=0x876543A1, o_rsp_valid 3 cycles after the load is accepted.
- Loads from that word:
  - LB 0x10 → 0xFFFFFFA1
  - LBU 0x13 → 0x00000087
  - LH 0x12 → 0xFFFF8765
  - LHU 0x10 → 0x000043A1
- SB 0x11 wdata 0x000000CC → one read then one write of 0x8765CCA1. Then SH 0x12 wdata 0x00001234 → 0x1234CCA1.
- LW 0x12, SH 0x13, SB with funct3 100 → o_rsp_error=1 and o_rsp_data=0 one cycle after accept. No mem strobes.
- Hold i_rsp_ready=0 for 3 cycles on an LB response → o_rsp_valid and o_rsp_data held, o_req_ready=0; handshake on cycle 4, ready the cycle after.
- Assert i_reset during MERGE of SB 0x10 wdata 0x55 → no o_mem_write. A later LW 0x10 returns the old word unchanged.
